// File: rtl/connect4_win_scanner.sv
// Sequential Connect 4 win/draw checker: copies the board into a local shadow
// through a single-cell read port, then walks every four-cell window for one player.
module connect4_win_scanner #(
    parameter int ROWS = 6,
    parameter int COLS = 7
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic [1:0] player,
    output logic [2:0] rd_row,
    output logic [2:0] rd_col,
    input  logic [1:0] rd_data,
    output logic       busy,
    output logic       done,
    output logic       win,
    output logic       draw,
    output logic [2:0] win_row,
    output logic [2:0] win_col,
    output logic [1:0] win_dir
);

    localparam int CELLS  = ROWS * COLS;
    localparam int CELL_W = $clog2(CELLS);
    localparam logic [2:0] LAST_ROW = 3'(ROWS - 1);
    localparam logic [2:0] LAST_COL = 3'(COLS - 1);

    typedef enum logic [1:0] {IDLE, CAPTURE, CHECK, DONE} state_t;

    state_t              state, state_nxt;
    logic [1:0]          player_q;
    logic                full_q;
    logic [2:0]          chk_row, chk_col;
    logic [1:0]          chk_dir;
    logic [1:0]          shadow [CELLS];
    logic [CELL_W-1:0]   cap_idx;
    logic                cap_last, chk_last, hit;

    assign cap_idx  = CELL_W'(int'(rd_row) * COLS + int'(rd_col));
    assign cap_last = (rd_row == LAST_ROW) && (rd_col == LAST_COL);
    assign chk_last = (chk_row == LAST_ROW) && (chk_col == LAST_COL) && (chk_dir == 2'd3);

    // Window evaluation: all four cells must be in bounds and equal a real player.
    always_comb begin
        int dr, dc, rr, cc;
        logic [CELL_W-1:0] idx;
        // NOTE: every variable written here gets a default first so no latch is inferred.
        dr  = 0;
        dc  = 1;
        rr  = 0;
        cc  = 0;
        idx = '0;
        case (chk_dir)
            2'd1:    begin dr = 1; dc = 0;  end
            2'd2:    begin dr = 1; dc = 1;  end
            2'd3:    begin dr = 1; dc = -1; end
            default: ;
        endcase
        hit = (player_q == 2'b01) || (player_q == 2'b10);
        if ((int'(chk_row) + 3 * dr > ROWS - 1) ||
            (int'(chk_col) + 3 * dc > COLS - 1) ||
            (int'(chk_col) + 3 * dc < 0)) begin
            hit = 1'b0;
        end else begin
            for (int k = 0; k < 4; k++) begin
                rr  = int'(chk_row) + k * dr;
                cc  = int'(chk_col) + k * dc;
                idx = CELL_W'(rr * COLS + cc);
                if (shadow[idx] != player_q) hit = 1'b0;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state <= IDLE;
        else      state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        busy      = 1'b0;
        done      = 1'b0;
        case (state)
            IDLE:    if (start) state_nxt = CAPTURE;
            CAPTURE: begin
                busy = 1'b1;
                if (cap_last) state_nxt = CHECK;
            end
            CHECK:   begin
                busy = 1'b1;
                if (hit || chk_last) state_nxt = DONE;
            end
            DONE:    begin
                done      = 1'b1;
                state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            player_q <= 2'b00;
            full_q   <= 1'b0;
            rd_row   <= 3'd0;
            rd_col   <= 3'd0;
            chk_row  <= 3'd0;
            chk_col  <= 3'd0;
            chk_dir  <= 2'd0;
            win      <= 1'b0;
            draw     <= 1'b0;
            win_row  <= 3'd0;
            win_col  <= 3'd0;
            win_dir  <= 2'd0;
        end else begin
            case (state)
                IDLE: if (start) begin
                    player_q <= player;
                    full_q   <= 1'b1;
                    rd_row   <= 3'd0;
                    rd_col   <= 3'd0;
                    chk_row  <= 3'd0;
                    chk_col  <= 3'd0;
                    chk_dir  <= 2'd0;
                    win      <= 1'b0;
                    draw     <= 1'b0;
                    win_row  <= 3'd0;
                    win_col  <= 3'd0;
                    win_dir  <= 2'd0;
                end
                CAPTURE: begin
                    full_q <= full_q & (rd_data != 2'b00);
                    if (cap_last) begin
                        rd_row <= 3'd0;
                        rd_col <= 3'd0;
                    end else if (rd_col == LAST_COL) begin
                        rd_col <= 3'd0;
                        rd_row <= rd_row + 3'd1;
                    end else begin
                        rd_col <= rd_col + 3'd1;
                    end
                end
                CHECK: begin
                    if (hit) begin
                        win     <= 1'b1;
                        win_row <= chk_row;
                        win_col <= chk_col;
                        win_dir <= chk_dir;
                    end else if (chk_last) begin
                        draw <= full_q;
                    end else if (chk_dir == 2'd3) begin
                        chk_dir <= 2'd0;
                        if (chk_col == LAST_COL) begin
                            chk_col <= 3'd0;
                            chk_row <= chk_row + 3'd1;
                        end else begin
                            chk_col <= chk_col + 3'd1;
                        end
                    end else begin
                        chk_dir <= chk_dir + 2'd1;
                    end
                end
                default: ;
            endcase
        end
    end

    // NOTE: the shadow is storage whose contents are always rewritten before use, so it has no reset.
    always_ff @(posedge clk) begin
        if (state == CAPTURE) shadow[cap_idx] <= rd_data;
    end

endmodule

// File: tb/tb_connect4_win_scanner.sv
// Directed bench for connect4_win_scanner: hand-computed board scenarios, with
// done timing, busy length, result fields, ignored start and mid-scan reset.
module tb_connect4_win_scanner;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       start = 1'b0;
    logic [1:0] player = 2'b00;
    logic [2:0] rd_row, rd_col;
    logic [1:0] rd_data;
    logic       busy, done, win, draw;
    logic [2:0] win_row, win_col;
    logic [1:0] win_dir;

    logic [1:0] board [6][7];
    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    assign rd_data = (rd_row < 3'd6 && rd_col < 3'd7) ? board[rd_row][rd_col] : 2'b00;

    connect4_win_scanner #(.ROWS(6), .COLS(7)) dut (
        .clk(clk), .rst(rst), .start(start), .player(player),
        .rd_row(rd_row), .rd_col(rd_col), .rd_data(rd_data),
        .busy(busy), .done(done), .win(win), .draw(draw),
        .win_row(win_row), .win_col(win_col), .win_dir(win_dir)
    );

    task automatic check(input string tag, input int got, input int exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic fill(input logic [1:0] v);
        for (int r = 0; r < 6; r++)
            for (int c = 0; c < 7; c++)
                board[r][c] = v;
    endtask

    task automatic run_scan(input string name, input logic [1:0] p, input int exp_edge,
                            input int ew, input int ed, input int er, input int ec,
                            input int edir, input int pulse_at);
        int e, busy_cnt, extra;
        @(negedge clk);
        start  = 1'b1;
        player = p;
        @(negedge clk);
        start  = 1'b0;
        player = p ^ 2'b11;
        e = 0;
        busy_cnt = 0;
        check({name, ".busy_after_accept"}, int'(busy), 1);
        while (!done && e < 300) begin
            if (busy) busy_cnt++;
            start = (e == pulse_at - 1);
            @(negedge clk);
            e++;
        end
        start = 1'b0;
        check({name, ".done_edge"}, e, exp_edge);
        check({name, ".busy_cycles"}, busy_cnt, exp_edge);
        check({name, ".busy_in_done"}, int'(busy), 0);
        check({name, ".win"}, int'(win), ew);
        check({name, ".draw"}, int'(draw), ed);
        check({name, ".win_row"}, int'(win_row), er);
        check({name, ".win_col"}, int'(win_col), ec);
        check({name, ".win_dir"}, int'(win_dir), edir);
        @(negedge clk);
        check({name, ".done_pulse_width"}, int'(done), 0);
        check({name, ".win_hold"}, int'(win), ew);
        check({name, ".draw_hold"}, int'(draw), ed);
        if (pulse_at >= 0) begin
            extra = 0;
            for (int i = 0; i < 220; i++) begin
                @(negedge clk);
                if (done) extra++;
            end
            check({name, ".extra_done"}, extra, 0);
        end
    endtask

    initial begin
        int e, dcount;
        fill(2'b00);
        repeat (2) @(negedge clk);
        check("reset.busy", int'(busy), 0);
        check("reset.done", int'(done), 0);
        check("reset.win", int'(win), 0);
        check("reset.draw", int'(draw), 0);
        check("reset.rd_row", int'(rd_row), 0);
        check("reset.rd_col", int'(rd_col), 0);
        check("reset.win_dir", int'(win_dir), 0);
        rst = 1'b1;

        run_scan("empty_p1", 2'b01, 210, 0, 0, 0, 0, 0, -1);

        fill(2'b00);
        for (int c = 0; c < 4; c++) board[0][c] = 2'b01;
        run_scan("horiz", 2'b01, 43, 1, 0, 0, 0, 0, -1);

        fill(2'b00);
        for (int r = 2; r < 6; r++) board[r][6] = 2'b10;
        run_scan("vert", 2'b10, 124, 1, 0, 2, 6, 1, -1);

        fill(2'b00);
        board[0][3] = 2'b01; board[1][2] = 2'b01; board[2][1] = 2'b01; board[3][0] = 2'b01;
        run_scan("antidiag", 2'b01, 58, 1, 0, 0, 3, 3, -1);

        fill(2'b00);
        for (int k = 0; k < 4; k++) board[1+k][1+k] = 2'b10;
        run_scan("diag", 2'b10, 77, 1, 0, 1, 1, 2, -1);
        run_scan("diag_other_player", 2'b01, 210, 0, 0, 0, 0, 0, -1);

        fill(2'b10);
        run_scan("full_p2_test_p1", 2'b01, 210, 0, 1, 0, 0, 0, -1);
        fill(2'b01);
        run_scan("full_p1_test_p1", 2'b01, 43, 1, 0, 0, 0, 0, -1);

        fill(2'b00);
        run_scan("player00_empty", 2'b00, 210, 0, 0, 0, 0, 0, -1);
        fill(2'b11);
        run_scan("player11_full", 2'b11, 210, 0, 1, 0, 0, 0, -1);

        fill(2'b00);
        run_scan("start_while_busy", 2'b01, 210, 0, 0, 0, 0, 0, 20);

        // Mid-scan reset: pull rst low before edge 30 of a scan.
        fill(2'b00);
        @(negedge clk);
        start  = 1'b1;
        player = 2'b01;
        @(negedge clk);
        start = 1'b0;
        e = 0;
        while (e < 29) begin
            @(negedge clk);
            e++;
        end
        rst = 1'b0;
        #1;
        check("midreset.busy", int'(busy), 0);
        check("midreset.done", int'(done), 0);
        check("midreset.rd_row", int'(rd_row), 0);
        check("midreset.rd_col", int'(rd_col), 0);
        check("midreset.win", int'(win), 0);
        repeat (2) @(negedge clk);
        rst = 1'b1;
        dcount = 0;
        for (int i = 0; i < 250; i++) begin
            @(negedge clk);
            if (done) dcount++;
        end
        check("midreset.no_done", dcount, 0);

        fill(2'b00);
        for (int r = 2; r < 6; r++) board[r][6] = 2'b10;
        run_scan("after_reset", 2'b10, 124, 1, 0, 2, 6, 1, -1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
